gcm_ctr_scheduler: RTL and testbench

GCM_CTR_SCHEDULER -- requirements
Module: gcm_ctr_scheduler

---
 rtl/gcm_pkg.sv | 24 ++
 rtl/gcm_tag_delay.sv | 31 +++
 rtl/gcm_ctr_scheduler.sv | 108 ++++++++++
 tb/tb_gcm_ctr_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM counter-block scheduler.
// Holds the FSM state encoding and the per-issue tag carried beside the AES pipe.
package gcm_pkg;

    localparam int PIPE_DEPTH_DEF = 16;
    localparam int IV_W           = 96;
    localparam int CTR_W          = 32;
    localparam int BLK_W          = IV_W + CTR_W;
    localparam int NB_W           = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_J0,
        ISSUE_CTR,
        DRAIN
    } state_t;

    typedef struct packed {
        logic valid;
        logic is_j0;
        logic last;
    } tag_t;

endpackage

// File: rtl/gcm_tag_delay.sv
// Fixed-latency shift register that mirrors the AES pipeline depth,
// so each result can be matched with the tag of the block that produced it.
module gcm_tag_delay
    import gcm_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [PIPE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[PIPE_DEPTH-1];

endmodule

// File: rtl/gcm_ctr_scheduler.sv
// GCM counter-mode block scheduler: issues J0 then N inc32 counter blocks
// into the AES pipeline, throttled by downstream result-buffer credits.
module gcm_ctr_scheduler
    import gcm_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int BUF_DEPTH  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [0:95]      i_iv,
    input  logic [0:31]      i_ctr0,
    input  logic [15:0]      i_num_blocks,
    input  logic             i_res_pop,
    output logic             o_busy,
    output logic             o_ctr_valid,
    output logic [0:127]     o_ctr_block,
    output logic             o_res_valid,
    output logic             o_res_is_j0,
    output logic             o_done
);

    localparam int CR_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(BUF_DEPTH);

    state_t state;
    state_t state_nxt;

    logic [0:IV_W-1]  iv_q;
    logic [0:CTR_W-1] ctr_q;
    logic [NB_W-1:0]  left_q;
    logic [CR_W-1:0]  credits;

    logic issue;
    logic last_issue;
    logic pop_ok;
    tag_t tag_in;
    tag_t tag_out;

    assign issue = ((state == ISSUE_J0) || (state == ISSUE_CTR))
                   && (credits != '0);

    // left_q still holds N while in ISSUE_J0, so N = 0 makes J0 the last block
    assign last_issue = issue &&
        (((state == ISSUE_J0) && (left_q == '0)) ||
         ((state == ISSUE_CTR) && (left_q == NB_W'(1))));

    assign pop_ok = i_res_pop && (credits != CR_MAX);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (i_start) state_nxt = ISSUE_J0;
            ISSUE_J0:  if (issue) state_nxt = (left_q == '0) ? DRAIN : ISSUE_CTR;
            ISSUE_CTR: if (last_issue) state_nxt = DRAIN;
            DRAIN:     if (o_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            iv_q    <= '0;
            ctr_q   <= '0;
            left_q  <= '0;
            credits <= CR_MAX;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && i_start) begin
                iv_q   <= i_iv;
                ctr_q  <= i_ctr0;
                left_q <= i_num_blocks;
            end else if (issue) begin
                ctr_q <= ctr_q + CTR_W'(1);
                if (state == ISSUE_CTR) left_q <= left_q - NB_W'(1);
            end
            // issue and pop together cancel, even with the pool full
            if (issue && !i_res_pop) begin
                credits <= credits - CR_W'(1);
            end else if (!issue && pop_ok) begin
                credits <= credits + CR_W'(1);
            end
        end
    end

    assign tag_in = '{valid: issue,
                      is_j0: issue && (state == ISSUE_J0),
                      last:  last_issue};

    gcm_tag_delay #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign o_busy      = (state != IDLE);
    assign o_ctr_valid = issue;
    assign o_ctr_block = {iv_q, ctr_q};
    assign o_res_valid = tag_out.valid;
    assign o_res_is_j0 = tag_out.valid && tag_out.is_j0;
    assign o_done      = tag_out.valid && tag_out.last;

endmodule

// File: tb/tb_gcm_ctr_scheduler.sv
// Self-checking bench for gcm_ctr_scheduler against a queue-based message model.
// Every cycle is compared; directed scenarios add explicit event counts.
module tb_gcm_ctr_scheduler;

    localparam int PD = 16;
    localparam int BD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [0:95]  i_iv;
    logic [0:31]  i_ctr0;
    logic [15:0]  i_num_blocks;
    logic         i_res_pop;
    logic         o_busy;
    logic         o_ctr_valid;
    logic [0:127] o_ctr_block;
    logic         o_res_valid;
    logic         o_res_is_j0;
    logic         o_done;

    always #5 clk = ~clk;

    gcm_ctr_scheduler #(
        .PIPE_DEPTH(PD),
        .BUF_DEPTH (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_iv        (i_iv),
        .i_ctr0      (i_ctr0),
        .i_num_blocks(i_num_blocks),
        .i_res_pop   (i_res_pop),
        .o_busy      (o_busy),
        .o_ctr_valid (o_ctr_valid),
        .o_ctr_block (o_ctr_block),
        .o_res_valid (o_res_valid),
        .o_res_is_j0 (o_res_is_j0),
        .o_done      (o_done)
    );

    typedef struct {
        int due;
        bit j0;
        bit last;
    } res_t;

    res_t        q[$];
    bit          m_active;
    bit          m_fresh;
    int          m_issued;
    int          m_credits;
    int          m_n;
    int          cyc;
    logic [95:0] m_iv;
    logic [31:0] m_ctr0;

    int checks;
    int failures;
    int n_issue;
    int n_res;
    int n_done;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model with this cycle's inputs.
    task automatic tick();
        bit          e_issue;
        bit          e_rv;
        bit          e_j0;
        bit          e_last;
        logic [31:0] w;
        @(negedge clk);
        e_issue = m_active && (m_issued <= m_n) && (m_credits > 0);
        e_rv    = (q.size() > 0) && (q[0].due == cyc);
        e_j0    = e_rv && q[0].j0;
        e_last  = e_rv && q[0].last;
        chk1("busy", o_busy, m_active);
        chk1("ctr_valid", o_ctr_valid, e_issue);
        chk1("res_valid", o_res_valid, e_rv);
        chk1("res_is_j0", o_res_is_j0, e_j0);
        chk1("done", o_done, e_last);
        if (e_issue) begin
            w = m_ctr0 + 32'(m_issued);
            chkw("ctr_block", o_ctr_block, {m_iv, w});
        end else if (m_fresh) begin
            chkw("ctr_block_reset", o_ctr_block, '0);
        end
        n_issue += int'(o_ctr_valid);
        n_res   += int'(o_res_valid);
        n_done  += int'(o_done);
        if (rst) begin
            m_active  = 1'b0;
            m_fresh   = 1'b1;
            m_credits = BD;
            m_issued  = 0;
            q.delete();
        end else begin
            if (e_issue) begin
                q.push_back('{cyc + PD, m_issued == 0, m_issued == m_n});
                m_issued++;
            end
            if (e_issue && !i_res_pop) m_credits--;
            else if (!e_issue && i_res_pop && m_credits < BD) m_credits++;
            if (e_rv) void'(q.pop_front());
            if (m_active && e_last) begin
                m_active = 1'b0;
            end else if (!m_active && i_start) begin
                m_active = 1'b1;
                m_fresh  = 1'b0;
                m_iv     = i_iv;
                m_ctr0   = i_ctr0;
                m_n      = int'(i_num_blocks);
                m_issued = 0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [95:0] iv, input logic [31:0] c0,
                             input int n);
        i_start      = 1'b1;
        i_iv         = iv;
        i_ctr0       = c0;
        i_num_blocks = 16'(n);
        tick();
        i_start = 1'b0;
    endtask

    // mode 0: no pops, 1: always pop, 2: random pops and stray starts
    task automatic run_msg(input int mode, input int budget);
        for (int i = 0; i < budget && (o_busy || m_active); i++) begin
            i_res_pop = (mode == 1) || (mode == 2 && ($urandom % 4) != 0);
            if (mode == 2 && ($urandom % 6) == 0 && o_busy) begin
                i_start      = 1'b1;
                i_iv         = {$urandom, $urandom, $urandom};
                i_ctr0       = $urandom;
                i_num_blocks = 16'($urandom_range(0, 30));
            end
            tick();
            i_start = 1'b0;
        end
        i_res_pop = 1'b0;
        chk1("drain_timeout", o_busy, 1'b0);
    endtask

    task automatic refill();
        i_res_pop = 1'b1;
        for (int i = 0; i < BD + 3; i++) tick();
        i_res_pop = 1'b0;
    endtask

    int base;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        n_issue = 0; n_res = 0; n_done = 0;
        m_active = 1'b0; m_fresh = 1'b1; m_credits = BD;
        m_issued = 0; m_n = 0; m_iv = '0; m_ctr0 = '0;
        rst = 1'b1; i_start = 1'b0; i_res_pop = 1'b0;
        i_iv = '0; i_ctr0 = '0; i_num_blocks = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();

        // J0 and three data blocks back to back, results 16 later
        base = n_issue;
        start_msg(96'hCAFEBABE_DEADBEEF_01234567, 32'h1, 3);
        for (int i = 0; i < 4; i++) tick();
        chki("burst_issues", n_issue - base, 4);
        base = n_done;
        run_msg(0, 100);
        chki("burst_done", n_done - base, 1);
        refill();

        // inc32 wrap keeps IV intact
        start_msg({$urandom, $urandom, $urandom}, 32'hFFFF_FFFE, 2);
        run_msg(1, 100);

        // N = 0: only J0, tag mask and done coincide
        base = n_issue;
        start_msg({$urandom, $urandom, $urandom}, $urandom, 0);
        run_msg(1, 100);
        chki("n0_issues", n_issue - base, 1);

        // credit stall with no pops, single-pop release, then pop+issue
        refill();
        base = n_issue;
        start_msg({$urandom, $urandom, $urandom}, $urandom, 10);
        for (int i = 0; i < 30; i++) tick();
        chki("stall_issues", n_issue - base, 4);
        chk1("stall_busy", o_busy, 1'b1);
        i_res_pop = 1'b1;
        tick();
        i_res_pop = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chki("one_pop_issue", n_issue - base, 5);
        run_msg(1, 200);
        chki("stall_total", n_issue - base, 11);

        // start while busy is ignored
        refill();
        base = n_issue;
        start_msg(96'h0123_4567_89AB_CDEF_0011_2233, 32'h10, 5);
        tick(); tick();
        start_msg(96'hFFFF_0000_FFFF_0000_FFFF_0000, 32'h99, 9);
        run_msg(1, 200);
        chki("busy_start_issues", n_issue - base, 6);

        // reset mid-message flushes everything
        refill();
        start_msg({$urandom, $urandom, $urandom}, $urandom, 10);
        i_res_pop = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        i_res_pop = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = n_res;
        for (int i = 0; i < 20; i++) tick();
        chki("post_reset_results", n_res - base, 0);
        start_msg({$urandom, $urandom, $urandom}, $urandom, 2);
        chk1("restart_busy", o_busy, 1'b1);
        run_msg(1, 100);

        // randomized messages with random pops and stray starts
        for (int k = 0; k < 12; k++) begin
            refill();
            start_msg({$urandom, $urandom, $urandom},
                      (k % 3 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                   : 32'($urandom),
                      $urandom_range(0, 12));
            run_msg(2, 400);
            run_msg(1, 400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
